// File: rtl/lights_pkg.sv
// Shared constants, state encoding and colour helper for the lights selector controller.
package lights_pkg;

  localparam int COLOUR_W = 3;

  localparam logic [COLOUR_W-1:0] COLOUR_MIN = 3'd1;
  localparam logic [COLOUR_W-1:0] COLOUR_MAX = 3'd6;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t CHECK  = 3'd1;
  localparam state_t STEP   = 3'd2;
  localparam state_t SETTLE = 3'd3;
  localparam state_t DONE   = 3'd4;
  localparam state_t FAIL   = 3'd5;
  localparam state_t ASTEP  = 3'd6;

  function automatic logic colour_legal(input logic [COLOUR_W-1:0] c);
    return (c >= COLOUR_MIN) && (c <= COLOUR_MAX);
  endfunction

endpackage

// File: rtl/lights_period_tick.sv
// Modulo-PERIOD counter with enable and clear; tick is high on the terminal-count cycle.
module lights_period_tick #(
  parameter int PERIOD = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_r;

  assign tick = en && (cnt_r == LAST);

  // Counter sits at zero whenever stepping is not enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr || !en) begin
      cnt_r <= '0;
    end else if (cnt_r == LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/lights_seq_ctrl.sv
// Drives the selector button one pulse at a time until colour_in matches a requested
// target, with an optional periodic auto-step while idle.
module lights_seq_ctrl
  import lights_pkg::*;
#(
  parameter int PERIOD    = 8,
  parameter int MAX_STEPS = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic [COLOUR_W-1:0] req_colour,
  output logic                req_ready,
  input  logic                auto_en,
  input  logic [COLOUR_W-1:0] colour_in,
  output logic                button_out,
  output logic                done,
  output logic                err,
  output logic                busy
);

  localparam int SW = $clog2(MAX_STEPS + 1);
  localparam logic [SW-1:0] STEP_LIMIT = SW'(MAX_STEPS);

  state_t              state_r;
  state_t              state_s;
  logic [COLOUR_W-1:0] target_r;
  logic [SW-1:0]       steps_r;
  logic                accept_s;
  logic                tick_en_s;
  logic                tick_s;

  assign accept_s  = req_valid && req_ready;
  assign tick_en_s = (state_r == IDLE) && auto_en;

  lights_period_tick #(
    .PERIOD(PERIOD)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (tick_en_s),
    .clr (accept_s),
    .tick(tick_s)
  );

  // Next-state decode; an accepted request always beats a coincident auto tick
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = colour_legal(req_colour) ? CHECK : FAIL;
        end else if (tick_s) begin
          state_s = ASTEP;
        end else begin
          state_s = IDLE;
        end
      end
      CHECK: begin
        if (colour_in == target_r) begin
          state_s = DONE;
        end else if (steps_r == STEP_LIMIT) begin
          state_s = FAIL;
        end else begin
          state_s = STEP;
        end
      end
      STEP:    state_s = SETTLE;
      SETTLE:  state_s = CHECK;
      DONE:    state_s = IDLE;
      FAIL:    state_s = IDLE;
      ASTEP:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, target and step bookkeeping; outputs are decoded from the next state
  // so they line up with the state they belong to
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      target_r   <= '0;
      steps_r    <= '0;
      button_out <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      req_ready  <= 1'b1;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        target_r <= req_colour;
      end else begin
        target_r <= target_r;
      end
      if (state_r == STEP) begin
        steps_r <= steps_r + SW'(1);
      end else if ((state_r == DONE) || (state_r == FAIL)) begin
        steps_r <= '0;
      end else begin
        steps_r <= steps_r;
      end
      button_out <= (state_s == STEP) || (state_s == ASTEP);
      done       <= (state_s == DONE);
      err        <= (state_s == FAIL);
      busy       <= (state_s != IDLE);
      req_ready  <= (state_s == IDLE);
    end
  end

endmodule

// File: doc/lights_seq_ctrl.md
Name: lights_seq_ctrl

Overview:
- Controller that sequences the 3-bit colour selector (colour cycles 1..6 while its button is high; button low holds colour and forces 0/7 to 1).
- Accepts a target-colour request over a valid/ready handshake and pulses button_out one cycle at a time until colour_in equals the target.
- Also offers an auto-cycle mode that steps the selector once every PERIOD cycles while idle.
- Sits between the user/control logic and the selector; it is the only driver of the selector's button.

Parameters:
- PERIOD, 8, cycles between auto-mode steps (>=2); counter width $clog2(PERIOD).
- MAX_STEPS, 7, step attempts per request before an error is reported.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset; clock clk
- req_valid  input  1  target request valid
- req_colour  input  3  target colour; legal values 1..6
- req_ready  output  1  high only in IDLE
- auto_en  input  1  enables periodic stepping while IDLE with no request pending
- colour_in  input  3  current selector colour, registered in the selector, valid one cycle after a button edge
- button_out  output  1  drive to the selector button
- done  output  1  one-cycle pulse when the target is reached
- err  output  1  one-cycle pulse on an illegal target or a timeout
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: button_out=0, done=0, err=0, busy=0, req_ready=1. State=IDLE, step count=0, period counter=0, target register=0.
- Handshake: a request is accepted on a cycle with req_valid && req_ready. req_colour is latched into the target register. req_ready drops on the next cycle.
- Illegal target (0 or 7) on acceptance: go to FAIL. Emit err for 1 cycle, then return to IDLE. No button activity.
- States and transitions:
  - IDLE: button_out=0.
    - On accept with legal target: go to CHECK.
    - Else if auto_en: the period counter counts. When it reaches PERIOD-1, go to ASTEP and clear the counter.
    - If auto_en is low, the counter holds at 0.
  - CHECK: button_out=0. Compare colour_in with target.
    - Equal: go to DONE.
    - Not equal and step count = MAX_STEPS: go to FAIL.
    - Otherwise: go to STEP.
  - STEP: button_out=1 for exactly one cycle, step count +1, then go to SETTLE.
  - SETTLE: button_out=0 for one cycle (the selector output updates), then go to CHECK.
  - DONE: done=1 for one cycle, clear step count, go to IDLE.
  - FAIL: err=1 for one cycle, clear step count, go to IDLE.
  - ASTEP: button_out=1 for one cycle, go to IDLE. No done pulse.
- Latency: a target already showing gives done 2 cycles after acceptance (CHECK, DONE). Each required step adds 3 cycles (STEP, SETTLE, CHECK).
- Wrap: the controller relies on the selector's 6 -> 1 wrap. The worst legal distance is 5 steps, so MAX_STEPS=7 gives margin. A selector at 0 reaches 1 after the first step.
- Simultaneous events: a request arriving while IDLE and the period counter at terminal count both occur → the request wins and the counter clears. auto_en is ignored while busy.
- Reset mid-operation: return to IDLE immediately with all outputs at reset values. An in-flight request is dropped and no done/err pulse is issued.
- done and err are never high in the same cycle.

Decomposition:
- Shared package lights_pkg holds:
  - the colour width constant (3);
  - COLOUR_MIN=1 and COLOUR_MAX=6;
  - the state enum: IDLE, CHECK, STEP, SETTLE, DONE, FAIL, ASTEP.
- One natural sub-module: lights_period_tick (free-running modulo-PERIOD counter with enable/clear, one-cycle tick output).

Test Plan:
- Reset, then colour_in=1 and request 4 → button_out pulses exactly 3 times, each 1 cycle wide, 2 low cycles between pulses. done arrives 11 cycles after accept. err stays 0.
- colour_in=5, request 2 (wrap 5→6→1→2) → 3 pulses, then done. Also colour_in=3, request 3 → zero pulses, done 2 cycles after accept.
- Request 0, then request 7 → each gives an err pulse 1 cycle after accept, no button activity, req_ready back high on the following cycle.
- colour_in held stuck at 2, request 5 → 7 pulses, then err (timeout), then IDLE.
- auto_en=1 with PERIOD=8 and no request → one button pulse every 9 cycles (8 counting cycles plus ASTEP). Raise req_valid on the terminal-count cycle → the request is accepted and no ASTEP pulse occurs.
- Assert rst during SETTLE of a 3-step request → next cycle button_out=0, busy=0, req_ready=1, no done or err pulse.
